mcs8_bus_resp: RTL
==================

// Module: mcs8_bus_resp
// PURPOSE
//  System-side responder for the MCS8 (8008) CPU multiplexed bus. Decodes the CPU T-state
//  outputs and SYNC; latches the low address at T1 and the high address plus cycle type at T2.
//  Performs the memory or I/O access and drives read data onto D at T3, or captures write data.
//  Holds READY_O low until the access completes. Sits between cpu and memory/port logic.
// PARAMETERS
//  ADDR_W    14  memory address width; fixed by the 8008 bus, do not change
//  WAIT_MAX  15  maximum T-wait slots per access; MEM_ACK_I timeout sets ERR_O
// PORTS
//  CLK_I        in   1   single system clock, rising edge
//  RSTN_I       in   1   asynchronous active-low reset
//  SYNC_I       in   1   one-CLK_I strobe per CPU T-state; STATE_I/D_I sampled when high
//  STATE_I      in   3   CPU S2:S0: T1=010 T1I=011 T2=001 WAIT=000 T3=100 STOP=110 T4=111 T5=101
//  D_I          in   8   CPU data bus, CPU-driven value
//  D_O          out  8   read data to the CPU
//  D_OE_O       out  1   D_O drive enable
//  READY_O      out  1   0 inserts T-wait after T2
//  MEM_ADDR_O   out  14  latched memory address
//  MEM_RD_O     out  1   memory read request, held until MEM_ACK_I
//  MEM_WR_O     out  1   memory write request, held until MEM_ACK_I
//  MEM_WDATA_O  out  8   write data
//  MEM_RDATA_I  in   8   read data, valid with MEM_ACK_I
//  MEM_ACK_I    in   1   one-cycle access completion
//  IO_PORT_O    out  5   I/O port number (T2 D5:D1)
//  IO_RD_O      out  1   one-cycle INP strobe (port 0-7); IO_RDATA_I sampled in the same cycle
//  IO_WR_O      out  1   one-cycle OUT strobe (port 8-31); data on MEM_WDATA_O
//  IO_RDATA_I   in   8   input port data
//  CYC_O        out  2   latched cycle type: 00 PCI, 01 PCR, 10 PCC, 11 PCW
//  ERR_O        out  1   sticky wait-timeout flag; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0, except READY_O=1. FSM is in IDLE. Reset is asynchronous and may occur
//   mid-access: requests drop immediately and nothing is retried.
//  All decoding happens only on cycles where SYNC_I=1. STATE_I values are not acted on otherwise.
//  FSM states:
//   IDLE:   T1 or T1I -> latch addr[7:0]=D_I, go to ADDR_H.
//   ADDR_H: T2 -> latch addr[13:8]=D_I[5:0], CYC_O=D_I[7:6], IO_PORT_O=D_I[5:1]; go to ACCESS.
//           Any state other than T2 -> IDLE.
//   ACCESS:
//    - PCI/PCR: assert MEM_RD_O. On MEM_ACK_I, capture MEM_RDATA_I and drop MEM_RD_O.
//    - PCW: wait for the T3 strobe, then MEM_WDATA_O=D_I and assert MEM_WR_O until MEM_ACK_I.
//    - PCC, port<8: pulse IO_RD_O and capture IO_RDATA_I.
//    - PCC, port>=8: pulse IO_WR_O with MEM_WDATA_O=latched low address (accumulator).
//   DRIVE: on the T3 strobe, D_OE_O=1 with the captured data (read cycles only). On the next
//          SYNC_I strobe, D_OE_O=0 and go to IDLE.
//  READY_O drops in the cycle the FSM enters ACCESS and rises in the cycle after data is
//   captured (read) or MEM_ACK_I arrives (write).
//  Each WAIT strobe increments a wait counter. On reaching WAIT_MAX: set ERR_O, force READY_O=1,
//   drive 0xFF on reads, drop requests, and complete the cycle.
//  MEM_ACK_I arriving in the same cycle as a SYNC_I strobe: the ack wins and READY_O is released
//   in the following cycle.
//  STOP state (HLT): FSM goes to IDLE. Outputs hold except D_OE_O=0.
//  A new T1 seen in any state aborts the current cycle and restarts at ADDR_H.
//  Address is latched verbatim; there is no wrap. PCW with CYC_O=11 never drives D_OE_O.
// STRUCTURE
//  Package mcs8_pkg:
//   - T-state encodings
//   - cycle-type codes
//   - FSM state enum (IDLE, ADDR_H, ACCESS, DRIVE)
//  Sub-module mcs8_tstate_dec: registered one-hot decode of STATE_I, qualified by SYNC_I.
//  Everything else is inline: FSM, address/data latches, wait counter.
// TESTING
//  1. PCI: T1 D=0x34, T2 D=0x12, ACK 2 cycles later with RDATA=0xA5
//     -> MEM_ADDR_O=0x1234, READY_O low then high, D_O=0xA5 with D_OE_O=1 at T3.
//  2. PCW: T1 0x00, T2 0xFF (cyc 11, addr 0x3F00), T3 D=0x5C
//     -> MEM_WR_O with WDATA=0x5C; D_OE_O stays 0.
//  3. PCC: T2 D=0x82 (port 1) -> one IO_RD_O pulse, D_O=IO_RDATA_I.
//     PCC: T2 D=0x90 (port 8) -> one IO_WR_O pulse with MEM_WDATA_O=latched T1 byte.
//  4. No MEM_ACK_I for 15 WAIT strobes -> ERR_O=1, D_O=0xFF, cycle completes, FSM returns to IDLE.
//  5. RSTN_I low while MEM_RD_O=1 -> all requests 0 and READY_O=1 immediately.
//     Next T1 decodes normally.
//  6. STOP after T1, then T1 again -> restart cleanly; no stray MEM_RD_O or MEM_WR_O.

Source files
------------

// File: rtl/mcs8_pkg.sv
//============================================================================
// Module : mcs8_pkg
// Desc   : Shared encodings for the 8008 multiplexed-bus responder.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package mcs8_pkg;

    // CPU S2:S0 T-state codes; the decoder turns these into one-hot bit positions
    localparam logic [2:0] TS_WAIT = 3'b000;
    localparam logic [2:0] TS_T2   = 3'b001;
    localparam logic [2:0] TS_T1   = 3'b010;
    localparam logic [2:0] TS_T1I  = 3'b011;
    localparam logic [2:0] TS_T3   = 3'b100;
    localparam logic [2:0] TS_T5   = 3'b101;
    localparam logic [2:0] TS_STOP = 3'b110;
    localparam logic [2:0] TS_T4   = 3'b111;

    localparam logic [1:0] CYC_PCI = 2'b00;
    localparam logic [1:0] CYC_PCR = 2'b01;
    localparam logic [1:0] CYC_PCC = 2'b10;
    localparam logic [1:0] CYC_PCW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR_H = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DRIVE  = 2'd3
    } fsm_e;

    // Cycles that return a byte to the CPU at T3 (memory reads and INP ports 0-7)
    function automatic logic drives_data(input logic [1:0] cyc, input logic [4:0] port);
        return (cyc == CYC_PCI) || (cyc == CYC_PCR) ||
               ((cyc == CYC_PCC) && (port[4:3] == 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcs8_tstate_dec.sv
//============================================================================
// Module : mcs8_tstate_dec
// Desc   : Registered one-hot decode of the CPU T-state, qualified by SYNC.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module mcs8_tstate_dec (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sync_i,
    input  logic [2:0] state_i,
    input  logic [7:0] d_i,
    output logic [7:0] ts_o,
    output logic [7:0] d_o
);

    logic [7:0] ts_q;
    logic [7:0] d_q;

    // ts_q is a one-cycle pulse; bit index equals the raw S2:S0 code
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
            d_q  <= '0;
        end else begin
            ts_q <= sync_i ? (8'b1 << state_i) : 8'b0;
            if (sync_i) begin
                d_q <= d_i;
            end
        end
    end

    assign ts_o = ts_q;
    assign d_o  = d_q;

endmodule

`default_nettype wire

// File: rtl/mcs8_bus_resp.sv
//============================================================================
// Module : mcs8_bus_resp
// Desc   : System-side responder for the 8008 multiplexed bus.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module mcs8_bus_resp
    import mcs8_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int WAIT_MAX = 15
) (
    input  logic              CLK_I,
    input  logic              RSTN_I,
    input  logic              SYNC_I,
    input  logic [2:0]        STATE_I,
    input  logic [7:0]        D_I,
    output logic [7:0]        D_O,
    output logic              D_OE_O,
    output logic              READY_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic              MEM_RD_O,
    output logic              MEM_WR_O,
    output logic [7:0]        MEM_WDATA_O,
    input  logic [7:0]        MEM_RDATA_I,
    input  logic              MEM_ACK_I,
    output logic [4:0]        IO_PORT_O,
    output logic              IO_RD_O,
    output logic              IO_WR_O,
    input  logic [7:0]        IO_RDATA_I,
    output logic [1:0]        CYC_O,
    output logic              ERR_O
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

    logic [7:0] ts;
    logic [7:0] dat;

    fsm_e              state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cyc_q, cyc_d;
    logic [4:0]        port_q, port_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              doe_q, doe_d;
    logic              ready_q, ready_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              io_rd_q, io_rd_d;
    logic              io_wr_q, io_wr_d;
    logic              err_q, err_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    mcs8_tstate_dec u_dec (
        .clk_i   (CLK_I),
        .rst_ni  (RSTN_I),
        .sync_i  (SYNC_I),
        .state_i (STATE_I),
        .d_i     (D_I),
        .ts_o    (ts),
        .d_o     (dat)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cyc_d    = cyc_q;
        port_d   = port_q;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        doe_d    = doe_q;
        ready_d  = ready_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        io_rd_d  = 1'b0;
        io_wr_d  = 1'b0;
        err_d    = err_q;
        wcnt_d   = wcnt_q;

        if (MEM_ACK_I) begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
        end

        if (ts[TS_T1] || ts[TS_T1I]) begin
            addr_d[7:0] = dat;
            state_d     = ST_ADDR_H;
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b0;
            doe_d       = 1'b0;
            ready_d     = 1'b1;
            wcnt_d      = '0;
        end else if (ts[TS_STOP]) begin
            state_d = ST_IDLE;
            doe_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR_H: begin
                    if (ts[TS_T2]) begin
                        addr_d[ADDR_W-1:8] = dat[ADDR_W-9:0];
                        cyc_d   = dat[7:6];
                        port_d  = dat[5:1];
                        state_d = ST_ACCESS;
                        ready_d = 1'b0;
                        wcnt_d  = '0;
                        case (dat[7:6])
                            CYC_PCI, CYC_PCR: mem_rd_d = 1'b1;
                            CYC_PCC: begin
                                if (dat[5:4] == 2'b00) begin
                                    io_rd_d = 1'b1;
                                end else begin
                                    io_wr_d = 1'b1;
                                    wdata_d = addr_q[7:0];
                                end
                            end
                            default: ;
                        endcase
                    end else if (|ts) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Completion is checked before the WAIT count so an ack beats a same-cycle strobe
                    if (mem_rd_q && MEM_ACK_I) begin
                        rdata_d = MEM_RDATA_I;
                        ready_d = 1'b1;
                        state_d = ST_DRIVE;
                    end else if (mem_wr_q && MEM_ACK_I) begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (io_rd_q) begin
                        rdata_d = IO_RDATA_I;
                        ready_d = 1'b1;
                        state_d = ST_DRIVE;
                    end else if (io_wr_q) begin
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (ts[TS_WAIT]) begin
                        if (wcnt_q == WCNT_LAST) begin
                            err_d    = 1'b1;
                            ready_d  = 1'b1;
                            mem_rd_d = 1'b0;
                            mem_wr_d = 1'b0;
                            if (drives_data(cyc_q, port_q)) begin
                                rdata_d = 8'hFF;
                                state_d = ST_DRIVE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end else if (ts[TS_T3] && (cyc_q == CYC_PCW) && !mem_wr_q) begin
                        wdata_d  = dat;
                        mem_wr_d = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (!doe_q) begin
                        if (ts[TS_T3]) begin
                            doe_d = 1'b1;
                        end
                    end else if (|ts) begin
                        doe_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            cyc_q    <= '0;
            port_q   <= '0;
            rdata_q  <= '0;
            wdata_q  <= '0;
            doe_q    <= 1'b0;
            ready_q  <= 1'b1;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            io_rd_q  <= 1'b0;
            io_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cyc_q    <= cyc_d;
            port_q   <= port_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            doe_q    <= doe_d;
            ready_q  <= ready_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            io_rd_q  <= io_rd_d;
            io_wr_q  <= io_wr_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign D_O         = rdata_q;
    assign D_OE_O      = doe_q;
    assign READY_O     = ready_q;
    assign MEM_ADDR_O  = addr_q;
    assign MEM_RD_O    = mem_rd_q;
    assign MEM_WR_O    = mem_wr_q;
    assign MEM_WDATA_O = wdata_q;
    assign IO_PORT_O   = port_q;
    assign IO_RD_O     = io_rd_q;
    assign IO_WR_O     = io_wr_q;
    assign CYC_O       = cyc_q;
    assign ERR_O       = err_q;

endmodule

`default_nettype wire
